// File: rtl/ball_renderer.sv
// Pixel-rate ball renderer: frame-latched ball geometry feeding a 2-stage
// distance-test pipeline, with syncs and video enable delayed to match the colour.
module ball_renderer (
  input  logic       vga_clk,
  input  logic       Reset_n,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       vde,
  input  logic       hsync,
  input  logic       vsync,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic       vde_o,
  output logic       hsync_o,
  output logic       vsync_o
);

  localparam logic [11:0] BALL_COLOR = 12'hF70;
  localparam logic [11:0] BG_COLOR   = 12'h00F;

  // Frame-latched geometry and vsync edge detector
  logic              vsync_d_q;
  logic [9:0]        sx_q, sy_q, ss_q;
  logic [9:0]        sx_d, sy_d, ss_d;
  logic              vs_fall_s;

  // Stage 1
  logic signed [10:0] dx_q, dy_q, dx_d, dy_d;
  logic [19:0]        s2_q, s2_d;
  logic               ball_en_q, ball_en_d;
  logic               vde1_q, hs1_q, vs1_q;

  // Stage 2 / outputs
  logic signed [21:0] dx_ext_s, dy_ext_s, sqx_s, sqy_s;
  logic [21:0]        d2_s;
  logic               in_ball_s;
  logic [11:0]        rgb_q, rgb_d;
  logic               vde_o_q, hs_o_q, vs_o_q;

  // Shadow geometry next-state: load only on a detected vsync falling edge
  always_comb begin
    vs_fall_s = vsync_d_q & ~vsync;
    sx_d = sx_q;
    sy_d = sy_q;
    ss_d = ss_q;
    if (vs_fall_s) begin
      sx_d = BallX;
      sy_d = BallY;
      ss_d = BallS;
    end else begin
      sx_d = sx_q;
      sy_d = sy_q;
      ss_d = ss_q;
    end
  end

  // Stage 1 arithmetic uses the shadow values current at sampling time
  always_comb begin
    dx_d      = $signed({1'b0, DrawX} - {1'b0, sx_q});
    dy_d      = $signed({1'b0, DrawY} - {1'b0, sy_q});
    s2_d      = {10'd0, ss_q} * {10'd0, ss_q};
    ball_en_d = (ss_q != 10'd0);
  end

  // Stage 2: full-width squared distance and colour select
  always_comb begin
    dx_ext_s  = {{11{dx_q[10]}}, dx_q};
    dy_ext_s  = {{11{dy_q[10]}}, dy_q};
    sqx_s     = dx_ext_s * dx_ext_s;
    sqy_s     = dy_ext_s * dy_ext_s;
    d2_s      = $unsigned(sqx_s + sqy_s);
    in_ball_s = (d2_s <= {2'd0, s2_q}) && ball_en_q;
    rgb_d     = 12'h000;
    if (!vde1_q) begin
      rgb_d = 12'h000;
    end else if (in_ball_s) begin
      rgb_d = BALL_COLOR;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  // All state; syncs idle high so reset never emits a spurious sync pulse
  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      vsync_d_q <= 1'b1;
      sx_q      <= 10'd320;
      sy_q      <= 10'd240;
      ss_q      <= 10'd0;
      dx_q      <= 11'sd0;
      dy_q      <= 11'sd0;
      s2_q      <= 20'd0;
      ball_en_q <= 1'b0;
      vde1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      rgb_q     <= 12'h000;
      vde_o_q   <= 1'b0;
      hs_o_q    <= 1'b1;
      vs_o_q    <= 1'b1;
    end else begin
      vsync_d_q <= vsync;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ss_q      <= ss_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      s2_q      <= s2_d;
      ball_en_q <= ball_en_d;
      vde1_q    <= vde;
      hs1_q     <= hsync;
      vs1_q     <= vsync;
      rgb_q     <= rgb_d;
      vde_o_q   <= vde1_q;
      hs_o_q    <= hs1_q;
      vs_o_q    <= vs1_q;
    end
  end

  assign Red     = rgb_q[11:8];
  assign Green   = rgb_q[7:4];
  assign Blue    = rgb_q[3:0];
  assign vde_o   = vde_o_q;
  assign hsync_o = hs_o_q;
  assign vsync_o = vs_o_q;

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: directed test-plan cases plus
// randomized traffic against a per-pixel geometric reference model.
module tb_ball_renderer;

  logic       vga_clk = 1'b0;
  logic       Reset_n;
  logic [9:0] BallX, BallY, BallS, DrawX, DrawY;
  logic       vde, hsync, vsync;
  logic [3:0] Red, Green, Blue;
  logic       vde_o, hsync_o, vsync_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: latched geometry, previous vsync, one in-flight pixel
  int          msx, msy, mss;
  bit          mvsd;
  logic [14:0] st1, out_exp;

  localparam logic [11:0] BALL = 12'hF70;
  localparam logic [11:0] BG   = 12'h00F;
  localparam logic [14:0] IDLE = 15'h0003;

  ball_renderer dut (
    .vga_clk(vga_clk), .Reset_n(Reset_n),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .DrawX(DrawX), .DrawY(DrawY),
    .vde(vde), .hsync(hsync), .vsync(vsync),
    .Red(Red), .Green(Green), .Blue(Blue),
    .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_rgb(int x, int y, bit v);
    int dxm, dym;
    if (!v) return 12'h000;
    dxm = x - msx;
    dym = y - msy;
    if (mss != 0 && (dxm * dxm + dym * dym) <= mss * mss) return BALL;
    return BG;
  endfunction

  // One clock: advance the model across the edge, then compare every output
  task automatic step();
    logic [14:0] rec;
    rec = {model_rgb(int'(DrawX), int'(DrawY), vde), vde, hsync, vsync};
    if (!Reset_n) begin
      out_exp = IDLE;
      st1 = IDLE;
      msx = 320; msy = 240; mss = 0; mvsd = 1'b1;
    end else begin
      out_exp = st1;
      st1 = rec;
      if (mvsd && !vsync) begin
        msx = int'(BallX); msy = int'(BallY); mss = int'(BallS);
      end
      mvsd = vsync;
    end
    @(posedge vga_clk);
    #1;
    check_eq("pipe", {17'd0, Red, Green, Blue, vde_o, hsync_o, vsync_o}, {17'd0, out_exp});
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    DrawX = 10'(x); DrawY = 10'(y); vde = 1'b1;
    step();
    step();
    check_eq(tag, {20'd0, Red, Green, Blue}, {20'd0, exp});
  endtask

  task automatic latch(input int x, input int y, input int s);
    BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  initial begin
    Reset_n = 1'b0;
    BallX = 10'd0; BallY = 10'd0; BallS = 10'd0;
    DrawX = 10'd320; DrawY = 10'd240;
    vde = 1'b1; hsync = 1'b1; vsync = 1'b1;
    st1 = IDLE; out_exp = IDLE;
    msx = 320; msy = 240; mss = 0; mvsd = 1'b1;

    // Reset held with vde high
    repeat (3) step();
    check_eq("rst_rgb", {20'd0, Red, Green, Blue}, 32'd0);
    check_eq("rst_vde", {31'd0, vde_o}, 32'd0);
    check_eq("rst_hs", {31'd0, hsync_o}, 32'd1);
    check_eq("rst_vs", {31'd0, vsync_o}, 32'd1);
    Reset_n = 1'b1;
    pix("rst_bg", 320, 240, BG);

    // Latch and draw, inclusive boundary
    latch(320, 240, 16);
    pix("centre", 320, 240, BALL);
    pix("edge_in", 336, 240, BALL);
    pix("edge_out", 337, 240, BG);
    pix("diag_in", 331, 251, BALL);
    pix("diag_out", 332, 252, BG);

    // No tearing between vsync edges
    BallX = 10'd100;
    pix("hold_old", 320, 240, BALL);
    pix("hold_new", 100, 240, BG);
    latch(100, 240, 16);
    pix("relatch", 100, 240, BALL);

    // Off-screen clipping through signed dx
    latch(5, 5, 16);
    pix("clip_in", 0, 0, BALL);
    pix("no_alias", 639, 0, BG);

    // Blanking and sync alignment
    DrawX = 10'd5; DrawY = 10'd5; vde = 1'b0;
    step(); step();
    check_eq("blank", {20'd0, Red, Green, Blue}, 32'd0);
    hsync = 1'b0;
    step();
    check_eq("hs_t1", {31'd0, hsync_o}, 32'd1);
    step();
    check_eq("hs_t2", {31'd0, hsync_o}, 32'd0);
    hsync = 1'b1;
    latch(320, 240, 0);
    pix("rad0", 320, 240, BG);

    // Reset mid-frame
    latch(320, 240, 16);
    pix("pre_rst", 320, 240, BALL);
    Reset_n = 1'b0;
    step();
    check_eq("mid_rst", {20'd0, Red, Green, Blue}, 32'd0);
    Reset_n = 1'b1;
    pix("post_rst", 320, 240, BG);
    latch(320, 240, 16);
    pix("post_relatch", 320, 240, BALL);

    // Randomized traffic checked every cycle by step()
    for (int i = 0; i < 4000; i++) begin
      if (vsync == 1'b0) vsync = 1'b1;
      else if ($urandom_range(0, 99) == 0) begin
        vsync = 1'b0;
        BallX = 10'($urandom_range(0, 700));
        BallY = 10'($urandom_range(0, 520));
        BallS = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'($urandom_range(0, 120));
      end
      if ($urandom_range(0, 19) == 0) BallX = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) hsync = ~hsync;
      Reset_n = ($urandom_range(0, 599) != 0);
      vde = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 0) begin
        DrawX = 10'($urandom_range(0, 1023));
        DrawY = 10'($urandom_range(0, 1023));
      end else begin
        int ox, oy;
        ox = msx + int'($urandom_range(0, 2 * mss + 8)) - mss - 4;
        oy = msy + int'($urandom_range(0, 2 * mss + 8)) - mss - 4;
        DrawX = 10'((ox < 0) ? 0 : (ox > 1023) ? 1023 : ox);
        DrawY = 10'((oy < 0) ? 0 : (oy > 1023) ? 1023 : oy);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
